fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the single write port of the synchronous FIFO among NUM_REQ producers.
//   Round-robin arbitration with burst locking: a granted producer keeps the port
//   until it marks its last beat, hits MAX_BURST beats or drops valid.
//   Sits directly in front of the FIFO (drives wr_en/data_in, observes full).
// PARAMETERS
//   NUM_REQ    = 4   number of producers (2..8)
//   DATA_WIDTH = 16  data width, equal to the FIFO data width
//   MAX_BURST  = 4   max beats per grant (1..15)
// PORTS
//   clk           in   1                     rising-edge clock
//   rst           in   1                     synchronous reset, active-high
//   req_valid     in   NUM_REQ               producer i has a beat
//   req_last      in   NUM_REQ               beat from producer i is its last
//   req_data      in   NUM_REQ*DATA_WIDTH    producer i data, slice [i*DW +: DW]
//   req_ready     out  NUM_REQ               beat from producer i accepted this cycle
//   fifo_full     in   1                     FIFO full flag
//   fifo_wr_en    out  1                     FIFO write enable
//   fifo_data_in  out  DATA_WIDTH            FIFO write data
//   grant_id      out  $clog2(NUM_REQ)       current owner (valid while busy)
//   busy          out  1                     state == BURST
// BEHAVIOUR
//   - States: IDLE, BURST. Registers: state, owner, rr_ptr, beat_cnt.
//   - Reset (sampled at posedge): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
//     While rst=1: req_ready=0, fifo_wr_en=0, fifo_data_in=0, grant_id=0, busy=0.
//   - IDLE: if any req_valid, winner = first valid index at or after rr_ptr (mod
//     NUM_REQ); next cycle state=BURST, owner=winner, rr_ptr=winner+1 (mod), beat_cnt=0.
//     No beat is accepted in IDLE (one arbitration bubble per grant).
//   - BURST accept: req_ready[owner] = req_valid[owner] & ~fifo_full; others 0.
//     fifo_wr_en = req_ready[owner]; fifo_data_in = req_data[owner] (0 when no write).
//     Zero latency: combinational valid->wr_en path; write lands in FIFO same edge.
//   - BURST exit to IDLE at the edge where any of:
//       accepted beat with req_last[owner]=1;
//       accepted beat with beat_cnt == MAX_BURST-1;
//       req_valid[owner]=0 (producer idle releases lock).
//     Otherwise beat_cnt increments on each accepted beat.
//   - fifo_full=1 in BURST: no write, beat_cnt held, lock held (full is not a release).
//   - Simultaneous full and valid drop: valid drop wins, release.
//   - Non-owner valid/last ignored; producers must hold data while ready=0.
//   - rr_ptr wraps NUM_REQ-1 -> 0; beat_cnt is $clog2(MAX_BURST+1) bits, never wraps.
//   - Reset mid-burst: next cycle IDLE, partial burst abandoned, no write in rst cycle.
// TESTING
//   1 rst=1 with all req_valid=1 -> wr_en=0, all ready=0, busy=0, grant_id=0.
//   2 only producer 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd) -> 1 idle cycle,
//     grant_id=2, wr_en 3 cycles with those data, then busy=0.
//   3 all 4 producers valid continuously, last=0 -> grants 0,1,2,3,0; 4 beats each,
//     1 bubble between grants; 20 writes in 25 cycles.
//   4 producer 1 burst, fifo_full=1 for 3 cycles after beat 2 -> wr_en=0 3 cycles,
//     beats 3,4 resume, total 4 writes, lock never lost.
//   5 producer 0 drops valid after 1 beat, producer 3 waiting -> release, grant_id=3
//     after bubble, producer 0 only 1 write.
//   6 rst pulsed mid-burst of producer 3 -> next cycle IDLE, rr_ptr=0, producer 0
//     (if valid) wins before producer 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a synchronous FIFO. A granted producer
// holds the port for a burst until it sends its last beat, reaches MAX_BURST beats, or goes idle.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_reg;
    logic [IDW-1:0]  owner_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [CW-1:0]   beat_cnt_reg;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  owner_valid;
    logic                  owner_last;
    logic                  accept;
    logic                  burst_done;
    logic                  win_found;
    logic [IDW-1:0]        win_idx;
    logic [IDW:0]          cand;
    logic [IDW-1:0]        rr_ptr_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = accept && (owner_reg == IDW'(gi));
        end
    endgenerate

    assign owner_valid = req_valid[owner_reg];
    assign owner_last  = req_last[owner_reg];

    // Outputs are gated by rst so nothing leaks out during a synchronous reset mid-burst.
    assign accept       = !rst && (state_reg == BURST) && owner_valid && !fifo_full;
    assign burst_done   = owner_last || (beat_cnt_reg == CW'(MAX_BURST - 1));
    assign fifo_wr_en   = accept;
    assign fifo_data_in = accept ? data_arr[owner_reg] : '0;
    assign grant_id     = rst ? '0 : owner_reg;
    assign busy         = !rst && (state_reg == BURST);

    // Scan from the highest offset down so the nearest valid index at/after rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    assign rr_ptr_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg    <= BURST;
                        owner_reg    <= win_idx;
                        rr_ptr_reg   <= rr_ptr_next;
                        beat_cnt_reg <= '0;
                    end
                end
                BURST: begin
                    // A full FIFO only stalls; losing valid is what releases the lock.
                    if (!owner_valid) begin
                        state_reg <= IDLE;
                    end else if (accept) begin
                        if (burst_done) begin
                            state_reg <= IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round-robin rotation,
// FIFO-full stall, valid-drop release and reset mid-burst.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_in;
    logic [1:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic        t4_full [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic        t4_wr   [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    logic [15:0] t4_data [9] = '{16'h0, 16'h0101, 16'h0102, 16'h0, 16'h0, 16'h0,
                                 16'h0103, 16'h0104, 16'h0};

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_data_in(fifo_data_in),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            $display("chk %s obs=%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int writes;
        int w0;
        int beat;

        // Test 1: reset with every producer requesting
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) set_data(i, 16'h5500 + 16'(i));
        step();
        step();
        settle();
        check("t1_wr_en", fifo_wr_en, 0);
        check("t1_ready", req_ready, 0);
        check("t1_busy", busy, 0);
        check("t1_grant", grant_id, 0);
        check("t1_data", fifo_data_in, 0);
        rst       = 1'b0;
        req_valid = '0;
        step();

        // Test 2: producer 2 sends A1,A2,A3 with last on the third
        req_valid = 4'b0100;
        set_data(2, 16'h00A1);
        settle();
        check("t2_bubble_wr", fifo_wr_en, 0);
        check("t2_bubble_busy", busy, 0);
        step();
        settle();
        check("t2_busy", busy, 1);
        check("t2_grant", grant_id, 2);
        check("t2_ready", req_ready, 4'b0100);
        check("t2_wr1", fifo_wr_en, 1);
        check("t2_data1", fifo_data_in, 16'h00A1);
        step();
        set_data(2, 16'h00A2);
        settle();
        check("t2_wr2", fifo_wr_en, 1);
        check("t2_data2", fifo_data_in, 16'h00A2);
        step();
        set_data(2, 16'h00A3);
        req_last[2] = 1'b1;
        settle();
        check("t2_wr3", fifo_wr_en, 1);
        check("t2_data3", fifo_data_in, 16'h00A3);
        step();
        req_valid = '0;
        req_last  = '0;
        settle();
        check("t2_end_busy", busy, 0);
        check("t2_end_wr", fifo_wr_en, 0);

        // Test 3: all producers valid, never last -> 0,1,2,3,0 in 25 cycles
        do_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, 16'hB000 + 16'(i));
        writes = 0;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) step();
            settle();
            check("t3_busy", busy, ((c % 5) != 0) ? 1 : 0);
            check("t3_wr", fifo_wr_en, ((c % 5) != 0) ? 1 : 0);
            if ((c % 5) != 0) begin
                check("t3_grant", grant_id, (c / 5) % 4);
                check("t3_data", fifo_data_in, 16'hB000 + (c / 5) % 4);
            end
            if (fifo_wr_en) writes++;
        end
        check("t3_writes", writes, 20);

        // Test 4: producer 1 burst, FIFO full for 3 cycles after beat 2
        do_reset();
        req_valid = 4'b0010;
        beat      = 1;
        writes    = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            if (c == 8) req_valid = '0;
            fifo_full = t4_full[c];
            set_data(1, 16'h0100 + 16'(beat));
            settle();
            check("t4_wr", fifo_wr_en, t4_wr[c]);
            check("t4_data", fifo_data_in, t4_data[c]);
            if (c >= 1 && c <= 7) begin
                check("t4_busy", busy, 1);
                check("t4_grant", grant_id, 1);
            end
            if (req_ready[1]) begin
                beat++;
                writes++;
            end
        end
        check("t4_end_busy", busy, 0);
        check("t4_writes", writes, 4);

        // Test 5: producer 0 drops valid after one beat (with full), producer 3 waits
        do_reset();
        req_valid = 4'b1001;
        set_data(0, 16'h0A01);
        set_data(3, 16'h0D01);
        w0 = 0;
        settle();
        check("t5_bubble_busy", busy, 0);
        check("t5_bubble_wr", fifo_wr_en, 0);
        if (req_ready[0]) w0++;
        step();
        settle();
        check("t5_grant0", grant_id, 0);
        check("t5_wr0", fifo_wr_en, 1);
        check("t5_data0", fifo_data_in, 16'h0A01);
        if (req_ready[0]) w0++;
        step();
        req_valid = 4'b1000;
        fifo_full = 1'b1;
        settle();
        check("t5_drop_busy", busy, 1);
        check("t5_drop_wr", fifo_wr_en, 0);
        check("t5_drop_data", fifo_data_in, 0);
        if (req_ready[0]) w0++;
        step();
        fifo_full = 1'b0;
        settle();
        check("t5_rel_busy", busy, 0);
        check("t5_rel_wr", fifo_wr_en, 0);
        step();
        settle();
        check("t5_grant3", grant_id, 3);
        check("t5_ready3", req_ready, 4'b1000);
        check("t5_data3", fifo_data_in, 16'h0D01);
        check("t5_p0_writes", w0, 1);
        req_valid = '0;

        // Test 6: reset mid-burst of producer 3, producer 0 then wins
        do_reset();
        req_valid = 4'b1000;
        set_data(3, 16'h0D02);
        set_data(0, 16'h0A02);
        settle();
        check("t6_bubble_busy", busy, 0);
        step();
        settle();
        check("t6_grant3", grant_id, 3);
        check("t6_wr3", fifo_wr_en, 1);
        step();
        rst       = 1'b1;
        req_valid = 4'b1001;
        settle();
        check("t6_rst_wr", fifo_wr_en, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_grant", grant_id, 0);
        check("t6_rst_data", fifo_data_in, 0);
        step();
        rst = 1'b0;
        settle();
        check("t6_idle_busy", busy, 0);
        check("t6_idle_wr", fifo_wr_en, 0);
        step();
        settle();
        check("t6_grant0", grant_id, 0);
        check("t6_wr0", fifo_wr_en, 1);
        check("t6_data0", fifo_data_in, 16'h0A02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
